pwm_capture: RTL
================

# pwm_capture

Input-capture peripheral that measures the period and high time of an external PWM-style signal in `clk` cycles, the receive-side counterpart of the PWM generator. It sits beside the PWM generator on the same 4-bit-address register bus. It uses the same `wr_en`/`rd_en`/`addr`/`wr_data`/`rd_data` convention, so software or loopback tests can check a generated waveform against its measured period and duty.

## Interface
- `WIDTH`, default 16: width of the counter, the capture registers and the bus data.
- `clk`  in  1: single clock for all logic.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `wr_en`  in  1: register write strobe, one write per cycle.
- `rd_en`  in  1: register read strobe.
- `addr`  in  4: register address.
- `wr_data`  in  WIDTH: write data.
- `rd_data`  out  WIDTH: read data. Combinational: the addressed register when `rd_en`=1, else 0.
- `pwm_in`  in  1: asynchronous measured signal.
- `cap_done`  out  1: one-cycle pulse on every completed capture.

## Operation
- Register map:
  - 0x0 CTRL (RW): bit0 `en`, bit1 `inv` (invert `pwm_in` before edge detection); other bits read 0.
  - 0x1 PERIOD (RO).
  - 0x2 HIGH (RO).
  - 0x3 STATUS: bit0 `valid` (RO), bit1 `ovf` (sticky, write-1-to-clear), bit2 `new` (sticky, write-1-to-clear).
- Unmapped addresses read 0; writes to them and to RO registers are ignored.
- Input path: 2-FF synchronizer, then optional inversion, then a delay flop. `rise` = s & ~s_d; `fall` = ~s & s_d.
- FSM states: IDLE, HIGH, LOW.
  - `en`=0: forced to IDLE with `cnt`=0.
  - IDLE: falling edges ignored. `rise` → HIGH, `cnt`<=1.
  - HIGH: `cnt`++. `fall` → LOW, `high_tmp`<=`cnt`.
  - LOW: `cnt`++. `rise` → PERIOD<=`cnt`, HIGH<=`high_tmp`, `valid`<=1, `new`<=1, `cap_done`=1, `cnt`<=1, next state HIGH.
- Counting rule: `cnt` is the number of cycles since the last rise, counting the cycle after the rise as 1. A waveform that is high 3 cycles with a 10-cycle period gives PERIOD=10, HIGH=3.
- PERIOD and HIGH always update in the same cycle, so a read never returns a mixed pair.
- Overflow: in HIGH or LOW, `cnt` = 2^WIDTH−1 with no edge in that cycle → `ovf`<=1, `valid`<=0, state → IDLE. PERIOD and HIGH hold their old values. Inputs stuck at constant 0 or constant 1 (0 % / 100 % duty) therefore report `ovf`.
- The first capture after enable needs two rising edges.
- Clearing `en` clears `valid`. PERIOD, HIGH, `ovf` and `new` hold their values.
- Same-cycle W1C and hardware set of `new` or `ovf`: the set wins.
- Writing CTRL with `inv` changed while `en`=1 has no automatic restart; software must toggle `en` to restart.
- Reset values: all registers and `cnt` are 0, state is IDLE, synchronizer flops are 0, `cap_done`=0, `rd_data`=0.

## Timing
- CTRL writes take effect at the next clock edge.
- `pwm_in` edge sampled at edge k: `rise`/`fall` are asserted in the cycle after edge k+1. PERIOD, HIGH, STATUS and `cap_done` change at edge k+2.
- Measurement offsets cancel because both edges see the same latency.
- Minimum measurable: a high phase and a low phase of at least 2 cycles each. Shorter pulses may be lost and produce no capture.
- `rd_data` has zero-cycle latency. A read in the same cycle as a capture returns the pre-capture value.
- `cap_done` is high exactly one cycle per capture and is never high in IDLE.

## Structure
- Shared package `pwm_pkg` holds:
  - register address constants: `ADDR_CTRL`, `ADDR_PERIOD`, `ADDR_HIGH`, `ADDR_STATUS`;
  - CTRL and STATUS bit indices;
  - the FSM state enum `cap_state_t`.
- Sub-module `pwm_edge_sync` contains the synchronizer, inversion and delay flop, and outputs `rise`/`fall`.
- The top block contains the FSM, counter, capture registers and bus decode.

## Test plan
- Reset, then read all addresses → all 0. Write CTRL=0x1, read it → 0x0001; read 0x7 → 0.
- `en`=1, `pwm_in` high 3 / low 7 cycles, repeated → first `cap_done` after the second rise, then PERIOD=10, HIGH=3, STATUS=0x5, and `cap_done` every 10 cycles.
- `inv`=1 with the same waveform → PERIOD=10, HIGH=7.
- `pwm_in` held at 1 for more than 65535 cycles (WIDTH=16) → `ovf`=1, `valid`=0, PERIOD and HIGH unchanged. Write STATUS=0x2 → `ovf`=0. Resume toggling → a new capture arrives after two rises.
- Write STATUS=0x4 in the same cycle as a capture → `new` reads 1. Clear `en` mid-HIGH → state IDLE, `valid`=0, no `cap_done`.
- Assert `rst_n` low mid-measurement → all outputs are 0 immediately, asynchronously; after release, measurement restarts from IDLE.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripherals: register map, control/status
// bit positions and the capture FSM state encoding.
package pwm_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_PERIOD = 4'h1;
  localparam logic [3:0] ADDR_HIGH   = 4'h2;
  localparam logic [3:0] ADDR_STATUS = 4'h3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_INV_BIT = 1;

  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_OVF_BIT   = 1;
  localparam int STAT_NEW_BIT   = 2;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_HIGH = 2'd1,
    CAP_LOW  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Brings the asynchronous measured signal into the clk domain, applies the
// optional inversion and produces single-cycle rise/fall strobes.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pwm,
  input  logic i_inv,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_s_d;
  logic w_s;

  // Inversion sits after the synchronizer so the delay flop compares like with like.
  assign w_s = r_sync2 ^ i_inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_s_d   <= 1'b0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
      r_s_d   <= w_s;
    end
  end

  assign o_rise = w_s & ~r_s_d;
  assign o_fall = ~w_s & r_s_d;

endmodule

// File: rtl/pwm_capture.sv
// Input-capture peripheral: measures period and high time of pwm_in in clk
// cycles and exposes them on the 4-bit-address register bus.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  input  logic             pwm_in,
  output logic             cap_done
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             r_en;
  logic             r_inv;
  cap_state_t       r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_high_tmp;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high;
  logic             r_valid;
  logic             r_ovf;
  logic             r_new;
  logic             r_cap_done;

  logic w_rise;
  logic w_fall;
  logic w_edge;
  logic w_wr_ctrl;
  logic w_wr_status;
  logic w_cnt_max;

  pwm_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pwm  (pwm_in),
    .i_inv  (r_inv),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_edge      = w_rise | w_fall;
  assign w_wr_ctrl   = wr_en && (addr == ADDR_CTRL);
  assign w_wr_status = wr_en && (addr == ADDR_STATUS);
  assign w_cnt_max   = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en  <= 1'b0;
      r_inv <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en  <= wr_data[CTRL_EN_BIT];
      r_inv <= wr_data[CTRL_INV_BIT];
    end
  end

  // W1C clears are applied first so a hardware set later in the block wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CAP_IDLE;
      r_cnt      <= '0;
      r_high_tmp <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_new      <= 1'b0;
      r_cap_done <= 1'b0;
    end else begin
      r_cap_done <= 1'b0;
      if (w_wr_status && wr_data[STAT_OVF_BIT]) r_ovf <= 1'b0;
      if (w_wr_status && wr_data[STAT_NEW_BIT]) r_new <= 1'b0;

      if (!r_en) begin
        r_state <= CAP_IDLE;
        r_cnt   <= '0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          CAP_IDLE: begin
            if (w_rise) begin
              r_state <= CAP_HIGH;
              r_cnt   <= CNT_ONE;
            end
          end
          CAP_HIGH: begin
            if (w_cnt_max && !w_edge) begin
              r_state <= CAP_IDLE;
              r_cnt   <= '0;
              r_ovf   <= 1'b1;
              r_valid <= 1'b0;
            end else if (w_fall) begin
              r_state    <= CAP_LOW;
              r_high_tmp <= r_cnt;
              r_cnt      <= r_cnt + CNT_ONE;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          CAP_LOW: begin
            if (w_cnt_max && !w_edge) begin
              r_state <= CAP_IDLE;
              r_cnt   <= '0;
              r_ovf   <= 1'b1;
              r_valid <= 1'b0;
            end else if (w_rise) begin
              r_state    <= CAP_HIGH;
              r_period   <= r_cnt;
              r_high     <= r_high_tmp;
              r_valid    <= 1'b1;
              r_new      <= 1'b1;
              r_cap_done <= 1'b1;
              r_cnt      <= CNT_ONE;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          default: begin
            r_state <= CAP_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign cap_done = r_cap_done;

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (addr)
        ADDR_CTRL: begin
          rd_data[CTRL_EN_BIT]  = r_en;
          rd_data[CTRL_INV_BIT] = r_inv;
        end
        ADDR_PERIOD: rd_data = r_period;
        ADDR_HIGH:   rd_data = r_high;
        ADDR_STATUS: begin
          rd_data[STAT_VALID_BIT] = r_valid;
          rd_data[STAT_OVF_BIT]   = r_ovf;
          rd_data[STAT_NEW_BIT]   = r_new;
        end
        default: rd_data = '0;
      endcase
    end
  end

endmodule
